// File: rtl/note_sequencer_if.sv
// Entry-load handshake carrying (nota, duracao) pairs into note_sequencer.
// The source drives master; the sequencer consumes slave.
interface note_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] nota;
  logic [7:0] duracao;

  modport master (output in_valid, output nota, output duracao, input in_ready);
  modport slave  (input in_valid, input nota, input duracao, output in_ready);
endinterface

// File: rtl/note_sequencer.sv
// Melody sequencer: queues (note, duration) entries, then plays them with an inter-note gap.
// Optional macro NOTE_SEQUENCER_LOOP_EN re-queues every played entry so the melody repeats until parar.
module note_sequencer #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int UNIT_CYCLES = 500000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int DEPTH       = 8
) (
  input  logic             clock,
  input  logic             reset,
  note_sequencer_if.slave  bus,
  input  logic             iniciar,
  input  logic             parar,
  output logic [11:0]      seletor,
  output logic             toca,
  output logic             tocando,
  output logic             fim_nota,
  output logic             vazio,
  output logic             cheio
);

  localparam int AW    = $clog2(DEPTH);
  localparam int DUR_W = 8 + $clog2(UNIT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int CNT_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;

`ifdef NOTE_SEQUENCER_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  if (UNIT_CYCLES < 1 || GAP_CYCLES < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0
      || CLOCK_FREQ < 1) begin : g_param_check
    $error("note_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {OCIOSO, CARREGA, SOM, PAUSA} state_t;

  typedef struct packed {
    logic [3:0] nota;
    logic [7:0] dur;
  } entry_t;

  // NOTE: the entry storage has no reset; only pointers and count define which slots are valid.
  entry_t r_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count, w_count_nxt;
  state_t           r_state, w_state_nxt, w_exit_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_nota, w_nota_nxt;
  logic [11:0]      r_seletor, w_seletor_nxt;
  logic             r_toca, r_tocando, r_fim_nota, r_vazio, r_cheio, r_in_ready;
  logic             w_toca_nxt, w_tocando_nxt;
  entry_t           w_head, w_wr_data;
  logic             w_push, w_pop, w_rewrite, w_wr_en;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_push    = bus.in_valid && r_in_ready;
  assign w_pop     = (r_state == CARREGA);
  assign w_rewrite = LOOP_EN && w_pop;
  assign w_wr_en   = w_push || w_rewrite;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path infers a latch.
    w_wr_data.nota = bus.nota;
    w_wr_data.dur  = bus.duracao;
    if (w_rewrite) w_wr_data = w_head;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Exit rule looks at the queue as it will be after this cycle's pop and push.
  assign w_exit_state = (w_count_nxt != '0) ? CARREGA : OCIOSO;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      OCIOSO: begin
        if (iniciar && !r_vazio) w_state_nxt = CARREGA;
      end
      CARREGA: begin
        if (w_head.dur == 8'd0) begin
          w_state_nxt = w_exit_state;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = SOM;
          w_cnt_nxt   = CNT_W'(w_head.dur) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
        end
      end
      SOM: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          w_state_nxt = PAUSA;
          w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          w_state_nxt = w_exit_state;
        end
      end
      PAUSA: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else             w_state_nxt = w_exit_state;
      end
      default: w_state_nxt = OCIOSO;
    endcase
    if (parar) begin
      w_state_nxt = OCIOSO;
      w_cnt_nxt   = '0;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    w_nota_nxt    = (r_state == CARREGA) ? w_head.nota : r_nota;
    w_toca_nxt    = (w_state_nxt == SOM) && (w_nota_nxt < 4'd12);
    w_seletor_nxt = w_toca_nxt ? (12'b1 << w_nota_nxt) : 12'h000;
    w_tocando_nxt = (w_state_nxt != OCIOSO);
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_state    <= OCIOSO;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cnt      <= '0;
      r_nota     <= '0;
      r_seletor  <= '0;
      r_toca     <= 1'b0;
      r_tocando  <= 1'b0;
      r_fim_nota <= 1'b0;
      r_vazio    <= 1'b1;
      r_cheio    <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nota     <= w_nota_nxt;
      r_seletor  <= w_seletor_nxt;
      r_toca     <= w_toca_nxt;
      r_tocando  <= w_tocando_nxt;
      r_fim_nota <= (w_state_nxt == SOM) && (w_cnt_nxt == '0);
      r_vazio    <= (w_count_nxt == '0);
      r_cheio    <= (w_count_nxt == (AW + 1)'(DEPTH));
      r_in_ready <= (w_count_nxt != (AW + 1)'(DEPTH)) && !(LOOP_EN && w_tocando_nxt);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign seletor      = r_seletor;
  assign toca         = r_toca;
  assign tocando      = r_tocando;
  assign fim_nota     = r_fim_nota;
  assign vazio        = r_vazio;
  assign cheio        = r_cheio;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder of the buzzer tone stage.
- Buffers a queue of (note, duration) entries written through a valid/ready handshake.
- On command, plays them in order: drives the 12-bit one-hot note selector and the play enable for exactly the programmed duration, then an inter-note silence.
- Lets the control FSM or a host load a melody and fire-and-forget playback.

Parameters:
- CLOCK_FREQ, 50000000: system clock frequency in Hz; documentation only, not used in arithmetic.
- UNIT_CYCLES, 500000: clock cycles per duration unit (10 ms at 50 MHz); must be ≥1.
- GAP_CYCLES, 1000000: silent cycles between consecutive notes (20 ms); 0 allowed.
- DEPTH, 8: queue entries; must be a power of 2, ≥2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; flushes the queue and returns to idle.
- in_valid  in  1  an entry is offered.
- in_ready  out  1  the queue accepts an entry (= !cheio).
- nota  in  4  note index 0..11 (0 = lowest pitch); 12..15 = rest.
- duracao  in  8  duration in units; 0 means skip the entry.
- iniciar  in  1  start playback pulse.
- parar  in  1  stop playback pulse.
- seletor  out  12  one-hot note selector, bit[nota] set; all zeros when silent.
- toca  out  1  sound enable.
- tocando  out  1  a playback session is active (any state other than OCIOSO).
- fim_nota  out  1  one-cycle pulse when a note's duration expires.
- vazio  out  1  queue empty.
- cheio  out  1  queue full.

Behaviour:
- Reset values: seletor=0, toca=0, tocando=0, fim_nota=0, vazio=1, cheio=0, in_ready=1; queue pointers and count cleared; state OCIOSO.
- All outputs are registered.
- Push: an entry is written when in_valid && in_ready at a clock edge.
  - When cheio=1, no write occurs, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: OCIOSO, CARREGA, SOM, PAUSA.
- OCIOSO:
  - toca=0, seletor=0.
  - iniciar && !vazio → CARREGA.
  - iniciar && vazio → ignored.
- CARREGA (1 cycle):
  - Pops the head entry and latches nota/duracao.
  - Loads the duration counter with duracao*UNIT_CYCLES; the counter is 8+ceil(log2(UNIT_CYCLES+1)) bits wide, no overflow.
  - duracao=0 → the entry is discarded with no sound and no fim_nota; next state follows the PAUSA exit rule, with no gap.
  - Otherwise → SOM.
- SOM:
  - Note 0..11: toca=1, seletor=one-hot(nota).
  - Rest (12..15): toca=0, seletor=0.
  - Held for exactly duracao*UNIT_CYCLES cycles.
  - On the last cycle, fim_nota=1 for one cycle.
  - Next state: PAUSA if GAP_CYCLES>0, else the exit rule.
- PAUSA:
  - toca=0, seletor=0 for exactly GAP_CYCLES cycles.
  - Then the exit rule applies.
- Exit rule: !vazio → CARREGA; vazio → OCIOSO.
- Latency: iniciar sampled at edge N → CARREGA during cycle N+1 → toca=1 from edge N+2.
- parar:
  - Has priority over every transition, in any state.
  - Next cycle: OCIOSO, toca=0, seletor=0, counters cleared.
  - The note being played is lost; remaining queue entries are kept.
  - A later iniciar resumes at the next entry.
- iniciar while tocando=1 is ignored.
- Pushes are accepted in every state, including during playback.
- reset mid-playback: all outputs take reset values on the next edge and queue contents are lost.

Optional Feature:
- Macro: NOTE_SEQUENCER_LOOP_EN.
- Defined:
  - In CARREGA, the popped entry is rewritten at the tail in the same cycle, so the melody repeats indefinitely until parar.
  - This applies to all entries, including duracao=0 ones.
  - in_ready=0 while tocando=1.
  - vazio never rises during playback.
- Not defined: entries are consumed once; playback ends in OCIOSO when the queue drains.

Test Plan (UNIT_CYCLES=4, GAP_CYCLES=2, DEPTH=4):
- Reset, then push {nota=5,dur=2}, then iniciar pulse.
  - toca=1, seletor=12'h020 for exactly 8 cycles starting 2 cycles after iniciar.
  - fim_nota on the 8th cycle.
  - 2 silent cycles, then OCIOSO with tocando=0 and vazio=1.
- Push {0,1}, {13,1}, {11,1}, then iniciar.
  - seletor 12'h001 for 4 cycles; gap of 2.
  - 4 silent cycles with fim_nota pulsing at the end; gap of 2.
  - seletor 12'h800 for 4 cycles.
  - 3 fim_nota pulses total.
- Push 5 entries back-to-back with in_valid held.
  - The first 4 are accepted.
  - cheio=1 and in_ready=0 on the 5th, which is not written.
  - A later drain plays exactly 4 notes.
- Push {3,0}, {4,1}, then iniciar.
  - The first entry produces no toca and no fim_nota.
  - seletor=12'h010 starts 2 cycles after the first CARREGA, i.e. back-to-back CARREGA with no gap.
- Push {2,3}, {7,1}, iniciar, then parar at the 5th SOM cycle.
  - Next cycle toca=0 and tocando=0; vazio=0 (one entry left).
  - A second iniciar plays seletor=12'h080 for 4 cycles.
- Assert reset mid-SOM with 2 entries queued.
  - Next edge: toca=0, seletor=0, vazio=1, tocando=0.
  - A subsequent iniciar is ignored.
  - With NOTE_SEQUENCER_LOOP_EN defined, 2 entries replay in order for at least 3 rounds until parar.
